// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch queue between a two-wide fetch stage and
//               the decoder. Bundles of two {pc, inst} pairs are written into
//               a circular buffer; the decoder pops 0, 1 or 2 entries per
//               cycle from the head. Flush and reset empty the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid,
    input  logic [W-1:0]             inst1,
    input  logic [W-1:0]             inst2,
    input  logic [W-1:0]             pc1,
    input  logic [W-1:0]             pc2,
    output logic                     stall_out,
    input  logic                     flush,
    input  logic [1:0]               deq_cnt,
    output logic                     out_valid1,
    output logic                     out_valid2,
    output logic [W-1:0]             out_inst1,
    output logic [W-1:0]             out_pc1,
    output logic [W-1:0]             out_inst2,
    output logic [W-1:0]             out_pc2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Each entry holds {pc, inst}; contents are never reset because the
    // output gating hides anything outside the occupied window.
    logic [2*W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_enq;
    logic [1:0]           w_deq_req;
    logic [1:0]           w_deq_eff;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [c_PTR_W-1:0]   w_wr_ptr_p1;
    logic [c_PTR_W-1:0]   w_rd_ptr_p1;
    logic [2*W-1:0]       w_head0;
    logic [2*W-1:0]       w_head1;

    // Stall only looks at the registered occupancy, so a same-cycle dequeue
    // never opens room for a bundle; this keeps the fetch stall path short.
    assign stall_out = (r_count > c_CNT_W'(DEPTH - 2));

    assign w_enq = fetch_valid & ~stall_out & ~flush;

    // A request of 3 is treated as 2, then limited to what is actually held
    // so the head never runs past the tail.
    assign w_deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
    assign w_deq_eff = (c_CNT_W'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;

    assign w_count_nxt = r_count + (w_enq ? c_CNT_W'(2) : c_CNT_W'(0))
                                 - c_CNT_W'(w_deq_eff);

    assign w_wr_ptr_p1 = r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_p1 = r_rd_ptr + c_PTR_W'(1);

    // Pointer and occupancy state; flush wins over any enqueue or dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_deq_eff);
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(2);
            end
            r_count <= w_count_nxt;
        end
    end

    // Storage write: the older instruction lands at the tail, the younger
    // one right behind it.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr]    <= {pc1, inst1};
            r_mem[w_wr_ptr_p1] <= {pc2, inst2};
        end
    end

    assign w_head0 = r_mem[r_rd_ptr];
    assign w_head1 = r_mem[w_rd_ptr_p1];

    assign out_valid1 = (r_count != '0);
    assign out_valid2 = (r_count >= c_CNT_W'(2));

    // Head entries are zeroed when not valid so stale storage never leaks.
    assign out_inst1 = out_valid1 ? w_head0[W-1:0]   : '0;
    assign out_pc1   = out_valid1 ? w_head0[2*W-1:W] : '0;
    assign out_inst2 = out_valid2 ? w_head1[W-1:0]   : '0;
    assign out_pc2   = out_valid2 ? w_head1[2*W-1:W] : '0;

    assign count = r_count;

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of entries; power of two, at least 4.
REQ-002 SHALL have parameter W, default 16, meaning width of the instruction and PC fields.
REQ-003 SHALL have port clk, input, 1, meaning system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 SHALL have port fetch_valid, input, 1, meaning a two-instruction fetch bundle is presented this cycle.
REQ-006 SHALL have ports inst1 and inst2, input, W, meaning the older and younger fetched instructions.
REQ-007 SHALL have ports pc1 and pc2, input, W, meaning the word addresses of inst1 and inst2.
REQ-008 SHALL have port stall_out, output, 1, meaning the queue cannot accept a bundle this cycle; drives the fetch stage stall.
REQ-009 SHALL have port flush, input, 1, meaning discard all queued entries (branch taken or redirect).
REQ-010 SHALL have port deq_cnt, input, 2, meaning number of entries the decoder consumes this cycle (0, 1 or 2; value 3 is treated as 2).
REQ-011 SHALL have ports out_valid1 and out_valid2, output, 1 each, meaning the oldest and second-oldest entries are present.
REQ-012 SHALL have ports out_inst1, out_pc1, out_inst2 and out_pc2, output, W each, meaning the contents of the two oldest entries.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1, meaning the number of occupied entries.

Function
REQ-014 SHALL store entries as {pc, inst} pairs in a circular buffer addressed by rd_ptr and wr_ptr, each clog2(DEPTH) bits wide and wrapping modulo DEPTH.
REQ-015 SHALL drive stall_out = (count > DEPTH-2), computed from the registered count only (no dependence on deq_cnt in the same cycle).
REQ-016 SHALL enqueue when fetch_valid=1, stall_out=0 and flush=0: write {pc1,inst1} at wr_ptr and {pc2,inst2} at wr_ptr+1, then advance wr_ptr by 2.
REQ-017 SHALL ignore a bundle (no write, no pointer change) when fetch_valid=1 and stall_out=1.
REQ-018 SHALL compute the effective dequeue count as deq_eff = min(clamped deq_cnt, count); any request beyond the occupied entries is silently dropped.
REQ-019 SHALL advance rd_ptr by deq_eff on each clock edge.
REQ-020 SHALL update count as count + 2*enq - deq_eff in the same cycle when enqueue and dequeue coincide.
REQ-021 SHALL drive out_valid1 = (count >= 1) and out_valid2 = (count >= 2), combinationally from state.
REQ-022 SHALL drive each out_inst/out_pc combinationally from the entries at rd_ptr and rd_ptr+1 when the matching valid is 1, and drive them to 0 when it is 0.
REQ-023 SHALL give flush priority over enqueue and dequeue: on the next edge rd_ptr=0, wr_ptr=0, count=0, and any bundle presented in the flush cycle is discarded.
REQ-024 SHALL have a latency of one cycle from enqueue to out_valid1 (entry written at edge N is visible after edge N).
REQ-025 SHALL have no bypass path from inst1/inst2 to the outputs within a cycle.
REQ-026 SHALL never let count exceed DEPTH and never let count underflow below 0.

Reset
REQ-027 SHALL, while rst=1, force rd_ptr=0, wr_ptr=0 and count=0 immediately, independent of clk.
REQ-028 SHALL, while rst=1, drive stall_out=0, out_valid1=0, out_valid2=0 and all out_inst/out_pc outputs to 0.
REQ-029 SHALL leave storage contents unreset; they are unobservable because of the gating in REQ-022.
REQ-030 SHALL, when rst asserts mid-operation, discard all entries with no partial state retained.

Verification
REQ-031 Fill: fetch_valid=1 for 4 cycles with deq_cnt=0 and pcs 0/1, 2/3, 4/5, 6/7 -> count reads 2, 4, 6, 8; stall_out=1 once count=8 (DEPTH=8); a fifth bundle is ignored and count stays 8.
REQ-032 Drain with wrap: from full, deq_cnt=2 for 4 cycles -> out_pc1/out_pc2 read 0/1, 2/3, 4/5, 6/7; then count=0 and both valids are 0. A refill then writes across the pointer wrap in the correct order.
REQ-033 Simultaneous: count=6, fetch_valid=1 with pcs 20/21, deq_cnt=1 -> stall_out=0 at the edge; next count=7; the 20/21 entries are placed last.
REQ-034 Over-dequeue: count=1, deq_cnt=2 -> next count=0, rd_ptr advances by 1 only, no underflow.
REQ-035 Flush: count=5, flush=1 with fetch_valid=1 and deq_cnt=2 in the same cycle -> next count=0, out_valid1=0, and the bundle presented that cycle is dropped.
REQ-036 Async reset: assert rst between clock edges at count=4 -> count=0, stall_out=0 and out_valid1=0 immediately, before the next edge.
